id_ex_stage_buf: RTL
====================

// Module: id_ex_stage_buf
// PURPOSE
// - Parametrised, elastic successor to the fixed ID/EX pipeline register; sits between decode and execute.
// - Carries PC+4, control word, two operands, extended immediate and the rs/rt/rd fields as one payload.
// - Adds valid/ready flow control, a 2-entry skid buffer, a synchronous flush, and a saturating back-pressure counter.
// - Replaces fixed delay-buffered inputs with cycle-accurate handshaking.
// PARAMETERS
// - XLEN     32  width of PC4, operand and immediate fields
// - CTRL_W   11  control-word width; bit layout is owned by the package
// - RA_W     5   width of one register-address field
// - NUM_RA   3   number of register-address fields (rs, rt, rd)
// - SKID_EN  1   1: 2-entry registered skid buffer; 0: single entry with combinational in_ready
// - CNT_W    16  width of the stall counter
// PORTS
// - clk          in   1              clock, rising edge
// - rst          in   1              asynchronous, active-high reset
// - flush        in   1              synchronous kill of all held entries (branch taken / hazard)
// - in_valid     in   1              decode payload valid
// - in_ready     out  1              stage can accept a payload this cycle
// - in_pc4       in   XLEN           PC+4 from decode
// - in_ctrl      in   CTRL_W         decoded control word
// - in_rdata1    in   XLEN           register-file read port 1
// - in_rdata2    in   XLEN           register-file read port 2
// - in_imm       in   XLEN           extended immediate
// - in_ra        in   NUM_RA*RA_W    packed {rs, rt, rd}
// - out_valid    out  1              execute payload valid
// - out_ready    in   1              execute accepts the payload
// - out_pc4/out_ctrl/out_rdata1/out_rdata2/out_imm/out_ra  out  as inputs   head-entry payload
// - stall_cnt    out  CNT_W          count of cycles with out_valid & !out_ready; saturates at all-ones
// BEHAVIOUR
// - Reset (async, rst=1): out_valid=0, in_ready=0 while rst is high, all payload outputs=0, stall_cnt=0.
// - Reset, cont.: on the first clk edge after release, in_ready=1 (SKID_EN=1).
// - Transfer rules:
//   - accept = in_valid & in_ready;  emit = out_valid & out_ready.
//   - The payload must not change while out_valid & !out_ready.
// - SKID_EN=1 state machine, entry counter 0..2:
//   - EMPTY -accept-> ONE.
//   - ONE -accept & !emit-> FULL (payload lands in the skid register).
//   - ONE -emit & !accept-> EMPTY.
//   - ONE -accept & emit-> ONE (head is replaced).
//   - FULL -emit-> ONE (skid moves to head in the same edge).
//   - in_ready = (state != FULL), driven straight from a flop; no combinational path from out_ready.
// - SKID_EN=0:
//   - in_ready = !out_valid | out_ready.
//   - Single register; a simultaneous accept and emit keeps out_valid=1.
// - Latency: an accepted payload appears at the outputs on the next edge (1 cycle) when the stage is empty.
// - flush (same edge, highest priority):
//   - All entries are invalidated and the state goes to EMPTY.
//   - A same-cycle accept is dropped.
//   - A same-cycle emit still counts as completed downstream.
// - Bubble masking: out_ctrl reads 0 whenever out_valid=0, so execute sees a NOP control word. Other payload fields hold stale data.
// - stall_cnt: increments by 1 when out_valid & !out_ready; holds at 2^CNT_W-1. Cleared only by rst, not by flush.
// - Reset mid-transfer: all held entries are lost. No partial payload reaches the outputs.
// STRUCTURE
// - Shared package pipe_pkg:
//   - ctrl_t with named bit fields: RegDst, Branch[1:0], MemRead, MemtoReg, ALUOp[2:0], MemWrite, ALUSrc, RegWrite.
//   - CTRL_NOP='0.
//   - Payload struct id_ex_payload_t.
//   - Default widths.
// - One sub-module: pipe_skid_buf #(W) is a generic 2-entry valid/ready skid on a flat W-bit vector.
//   - This block packs/unpacks the payload around it and adds the ctrl masking and stall_cnt.
// TESTING
// 1. Reset held 3 cycles, then released, with in_valid=1 and in_pc4=32'h0000_0004.
//    - Required: outputs 0 and in_ready=0 during reset.
//    - Required: next cycle out_valid=1 and out_pc4=32'h4.
// 2. Stream of 8 payloads (pc4=4,8,..,32) with out_ready=1.
//    - Required: one payload per cycle, in order, 1-cycle latency, in_ready stays 1.
// 3. out_ready=0 for 4 cycles while in_valid=1.
//    - Required: 2 payloads held, then in_ready=0.
//    - Required: stall_cnt=4 and out_pc4 stable.
//    - Required: after release, both payloads drain in order and none are lost.
// 4. flush asserted in FULL state, with in_valid=1 in the same cycle.
//    - Required: next cycle out_valid=0, out_ctrl=0, state EMPTY, and the new payload is dropped.
// 5. CNT_W=4, out_ready=0 for 20 cycles.
//    - Required: stall_cnt saturates at 4'hF and does not wrap.
// 6. SKID_EN=0 instance under back-pressure.
//    - Required: in_ready = !out_valid | out_ready in every cycle, and accept plus emit in one cycle keeps out_valid=1.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared ID/EX pipeline types: control-word layout, payload record and default widths.
package pipe_pkg;

  localparam int PIPE_XLEN   = 32;
  localparam int PIPE_CTRL_W = 11;
  localparam int PIPE_RA_W   = 5;
  localparam int PIPE_NUM_RA = 3;
  localparam int PIPE_CNT_W  = 16;

  typedef struct packed {
    logic       RegDst;
    logic [1:0] Branch;
    logic       MemRead;
    logic       MemtoReg;
    logic [2:0] ALUOp;
    logic       MemWrite;
    logic       ALUSrc;
    logic       RegWrite;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

  typedef struct packed {
    logic [PIPE_XLEN-1:0]             pc4;
    ctrl_t                            ctrl;
    logic [PIPE_XLEN-1:0]             rdata1;
    logic [PIPE_XLEN-1:0]             rdata2;
    logic [PIPE_XLEN-1:0]             imm;
    logic [PIPE_NUM_RA*PIPE_RA_W-1:0] ra;
  } id_ex_payload_t;

  function automatic int payload_width(input int xlen, input int ctrl_w,
                                       input int ra_w, input int num_ra);
    return 4 * xlen + ctrl_w + ra_w * num_ra;
  endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// Generic valid/ready buffer on a flat vector: 2-entry registered skid, or a
// single entry with pass-through ready when SKID_EN=0.
module pipe_skid_buf #(
  parameter int W       = 8,
  parameter bit SKID_EN = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic [1:0]   cnt_q, cnt_d;
  logic [W-1:0] head_q, head_d;
  logic [W-1:0] skid_q, skid_d;
  logic         rdy_q;
  logic         accept, emit;

  assign out_valid = (cnt_q != 2'd0);
  assign out_data  = head_q;
  assign emit      = out_valid & out_ready;
  // rdy_q stays low through reset so nothing is taken before the first edge after release
  assign in_ready  = SKID_EN ? rdy_q : (rdy_q & (~out_valid | out_ready));
  assign accept    = in_valid & in_ready;

  always_comb begin
    cnt_d  = cnt_q;
    head_d = head_q;
    skid_d = skid_q;
    if (flush) begin
      cnt_d = 2'd0;
    end else begin
      case (cnt_q)
        2'd0: begin
          if (accept) begin
            head_d = in_data;
            cnt_d  = 2'd1;
          end
        end
        2'd1: begin
          if (accept && emit) begin
            head_d = in_data;
          end else if (accept) begin
            if (SKID_EN) begin
              skid_d = in_data;
              cnt_d  = 2'd2;
            end
          end else if (emit) begin
            cnt_d = 2'd0;
          end
        end
        default: begin
          if (emit) begin
            head_d = skid_q;
            cnt_d  = 2'd1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= 2'd0;
      head_q <= '0;
      skid_q <= '0;
      rdy_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      head_q <= head_d;
      skid_q <= skid_d;
      rdy_q  <= SKID_EN ? (cnt_d != 2'd2) : 1'b1;
    end
  end

endmodule

// File: rtl/id_ex_stage_buf.sv
// Elastic ID/EX stage: packs the decode payload through a skid buffer, masks the
// control word on bubbles and counts back-pressure cycles.
module id_ex_stage_buf
  import pipe_pkg::*;
#(
  parameter int XLEN    = PIPE_XLEN,
  parameter int CTRL_W  = PIPE_CTRL_W,
  parameter int RA_W    = PIPE_RA_W,
  parameter int NUM_RA  = PIPE_NUM_RA,
  parameter bit SKID_EN = 1'b1,
  parameter int CNT_W   = PIPE_CNT_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [XLEN-1:0]        in_pc4,
  input  logic [CTRL_W-1:0]      in_ctrl,
  input  logic [XLEN-1:0]        in_rdata1,
  input  logic [XLEN-1:0]        in_rdata2,
  input  logic [XLEN-1:0]        in_imm,
  input  logic [NUM_RA*RA_W-1:0] in_ra,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [XLEN-1:0]        out_pc4,
  output logic [CTRL_W-1:0]      out_ctrl,
  output logic [XLEN-1:0]        out_rdata1,
  output logic [XLEN-1:0]        out_rdata2,
  output logic [XLEN-1:0]        out_imm,
  output logic [NUM_RA*RA_W-1:0] out_ra,
  output logic [CNT_W-1:0]       stall_cnt
);

  localparam int PW = payload_width(XLEN, CTRL_W, RA_W, NUM_RA);

  logic [PW-1:0]     in_data, out_data;
  logic [CTRL_W-1:0] ctrl_raw;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

  assign in_data = {in_pc4, in_ctrl, in_rdata1, in_rdata2, in_imm, in_ra};

  pipe_skid_buf #(.W(PW), .SKID_EN(SKID_EN)) u_skid (
    .clk      (clk),
    .rst      (rst),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data)
  );

  assign {out_pc4, ctrl_raw, out_rdata1, out_rdata2, out_imm, out_ra} = out_data;
  // Execute sees a NOP on bubbles; the data fields are left stale
  assign out_ctrl = out_valid ? ctrl_raw : CTRL_W'(CTRL_NOP);

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (out_valid && !out_ready && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule
